// File: rtl/rx32_pkg.sv
// Shared Rx32 definitions for the iterative multiply/divide unit: operation
// and state encodings, the iteration count and small two's-complement helpers.
package rx32_pkg;

  localparam int XLEN         = 32;
  localparam int MULDIV_ITERS = 32;
  localparam int CNT_W        = $clog2(MULDIV_ITERS);

  // Encodings follow the RV32M funct3 field directly.
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    WB   = 2'd3
  } muldiv_state_e;

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] x);
    return ~x + 64'd1;
  endfunction

  // Magnitude of x, treating it as signed only when asked to.
  function automatic logic [31:0] abs32(input logic [31:0] x, input logic is_signed);
    return (is_signed && x[31]) ? neg32(x) : x;
  endfunction

  // The upper funct3 bit separates divide/remainder from multiply.
  function automatic logic op_is_div(input muldiv_op_e op);
    return op[2];
  endfunction

  // rs1 is signed for MULH, MULHSU, DIV and REM.
  function automatic logic op_a_signed(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 is signed for MULH, DIV and REM (MULHSU treats it as unsigned).
  function automatic logic op_b_signed(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/rx32_muldiv.sv
// Rx32 iterative RV32M execution unit. Operands are reduced to magnitudes at
// start, 32 shift-add / restoring-divide steps run one per cycle, the sign is
// restored in FIX and the result leaves through a one-cycle write-back strobe.
module rx32_muldiv
  import rx32_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd,
  output logic            busy,
  output logic            wb_we,
  output logic [4:0]      wb_addr,
  output logic [XLEN-1:0] wb_data
);

  muldiv_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  muldiv_op_e       op_q;
  logic [4:0]       rd_q;
  logic [31:0]      a_q;        // |rs1| (multiplicand / unused for divide)
  logic [31:0]      b_q;        // |rs2| (divisor)
  logic             neg_q;      // product / quotient needs negation
  logic             a_neg_q;    // dividend was negative: remainder follows it
  logic             div0_q;     // divisor was zero at start
  logic [63:0]      prod_q;     // high half accumulates, low half holds multiplier bits
  logic [32:0]      rem_q;      // partial remainder
  logic [31:0]      quo_q;      // dividend shifts out of the top, quotient shifts in

  muldiv_op_e       op_in;
  logic             sa, sb;
  logic [32:0]      mul_sum;
  logic [32:0]      div_shift;
  logic [32:0]      div_diff;
  logic [63:0]      prod_fix;
  logic [31:0]      quo_fix;
  logic [31:0]      rem_fix;
  logic [31:0]      result;

  assign op_in = muldiv_op_e'(funct3);
  assign sa    = op_a_signed(op_in) & op_a[31];
  assign sb    = op_b_signed(op_in) & op_b[31];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state is always assigned with <= so every flop samples
    // pre-edge values regardless of the order of statements or blocks.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: a fixed walk IDLE -> RUN x32 -> FIX -> WB -> IDLE.
  always_comb begin
    // NOTE: the default at the top keeps this block free of inferred latches.
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (cnt_q == CNT_W'(MULDIV_ITERS - 1)) state_d = FIX;
      FIX:  state_d = WB;
      WB:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the state; a write to x0 is suppressed.
  always_comb begin
    busy  = (state_q != IDLE);
    wb_we = (state_q == WB) && (rd_q != 5'd0);
  end

  // One iteration step of each algorithm, computed from the current registers.
  always_comb begin
    mul_sum   = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, a_q} : 33'd0);
    div_shift = {rem_q[31:0], quo_q[31]};
    div_diff  = div_shift - {1'b0, b_q};
  end

  // Sign restoration and result selection used in FIX. A zero divisor drives
  // the quotient to all ones; the remainder path already ends up holding the
  // dividend in that case, so it needs no special handling.
  always_comb begin
    prod_fix = neg_q ? neg64(prod_q) : prod_q;
    quo_fix  = div0_q ? 32'hFFFF_FFFF : (neg_q ? neg32(quo_q) : quo_q);
    rem_fix  = a_neg_q ? neg32(rem_q[31:0]) : rem_q[31:0];
    unique case (op_q)
      OP_MUL:                       result = prod_fix[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = prod_fix[63:32];
      OP_DIV, OP_DIVU:              result = quo_fix;
      default:                      result = rem_fix;
    endcase
  end

  // Operand capture at start, one iteration per RUN cycle, result register in FIX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      op_q    <= OP_MUL;
      rd_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      neg_q   <= 1'b0;
      a_neg_q <= 1'b0;
      div0_q  <= 1'b0;
      prod_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      wb_addr <= '0;
      wb_data <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          cnt_q   <= '0;
          op_q    <= op_in;
          rd_q    <= rd;
          a_q     <= abs32(op_a, op_a_signed(op_in));
          b_q     <= abs32(op_b, op_b_signed(op_in));
          neg_q   <= sa ^ sb;
          a_neg_q <= sa;
          div0_q  <= (op_b == '0);
          prod_q  <= {32'd0, abs32(op_b, op_b_signed(op_in))};
          rem_q   <= '0;
          quo_q   <= abs32(op_a, op_a_signed(op_in));
        end
        RUN: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (op_is_div(op_q)) begin
            if (!div_diff[32]) begin
              rem_q <= div_diff;
              quo_q <= {quo_q[30:0], 1'b1};
            end else begin
              rem_q <= div_shift;
              quo_q <= {quo_q[30:0], 1'b0};
            end
          end else begin
            prod_q <= {mul_sum, prod_q[31:1]};
          end
        end
        FIX: begin
          wb_addr <= rd_q;
          wb_data <= result;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rx32_muldiv.sv
// Directed bench for rx32_muldiv: each operation is started at edge E0 and the
// write-back is checked against hand-computed values at E34.
module tb_rx32_muldiv;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd;
  logic        busy;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int n_checks = 0;
  int n_fail   = 0;

  rx32_muldiv dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .funct3  (funct3),
    .op_a    (op_a),
    .op_b    (op_b),
    .rd      (rd),
    .busy    (busy),
    .wb_we   (wb_we),
    .wb_addr (wb_addr),
    .wb_data (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start one operation at E0 and follow it to E34. With 'inject' set, a
  // second start with other operands is presented at E10 and must be ignored.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] r,
                        input logic [31:0] exp, input bit inject);
    bit          busy_ok;
    int          we_cnt;
    logic        we_e34;
    logic [4:0]  addr_e34;
    logic [31:0] data_e34;
    @(negedge clk);
    start = 1'b1; funct3 = f; op_a = a; op_b = b; rd = r;
    @(posedge clk);             // E0
    #1;
    start   = 1'b0;
    busy_ok = (busy === 1'b1);
    we_cnt  = 0;
    we_e34  = 1'b0;
    addr_e34 = '0;
    data_e34 = '0;
    for (int k = 1; k <= 34; k++) begin
      @(posedge clk);
      #1;
      if (k <= 33 && busy !== 1'b1) busy_ok = 0;
      if (wb_we === 1'b1) we_cnt++;
      if (k == 33) begin
        we_e34   = wb_we;
        addr_e34 = wb_addr;
        data_e34 = wb_data;
      end
      if (inject && k == 9) begin
        start = 1'b1; funct3 = 3'b000; op_a = 32'd11; op_b = 32'd13; rd = 5'd17;
      end
      if (inject && k == 10) start = 1'b0;
    end
    check({tag, " busy E0..E34"}, 32'(busy_ok), 32'd1);
    check({tag, " busy after E34"}, 32'(busy), 32'd0);
    if (r != 5'd0) begin
      check({tag, " wb_we pulses"}, 32'(we_cnt), 32'd1);
      check({tag, " wb_we at E34"}, 32'(we_e34), 32'd1);
      check({tag, " wb_addr"}, 32'(addr_e34), 32'(r));
      check({tag, " wb_data"}, data_e34, exp);
    end else begin
      check({tag, " no wb_we for x0"}, 32'(we_cnt), 32'd0);
    end
  endtask

  initial begin
    int we_seen;
    rst_n = 1'b0; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0; rd = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset wb_we", 32'(wb_we), 32'd0);
    check("reset wb_addr", 32'(wb_addr), 32'd0);
    check("reset wb_data", wb_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("MUL 7x6",        3'b000, 32'd7,         32'd6,         5'd5,  32'h0000_002A, 1'b0);
    run_op("MUL -1x3",       3'b000, 32'hFFFF_FFFF, 32'd3,         5'd6,  32'hFFFF_FFFD, 1'b0);
    run_op("MULH min*min",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd7,  32'h4000_0000, 1'b0);
    run_op("MULHSU -1*max",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 1'b0);
    run_op("MULHU max*max",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9,  32'hFFFF_FFFE, 1'b0);
    run_op("DIV -7/2",       3'b100, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFD, 1'b0);
    run_op("REM -7/2",       3'b110, 32'hFFFF_FFF9, 32'd2,         5'd11, 32'hFFFF_FFFF, 1'b0);
    run_op("DIVU 100/7",     3'b101, 32'd100,       32'd7,         5'd12, 32'd14,        1'b0);
    run_op("REMU 100/7",     3'b111, 32'd100,       32'd7,         5'd13, 32'd2,         1'b0);
    run_op("DIVU 5/0",       3'b101, 32'd5,         32'd0,         5'd14, 32'hFFFF_FFFF, 1'b0);
    run_op("DIV -5/0",       3'b100, 32'hFFFF_FFFB, 32'd0,         5'd15, 32'hFFFF_FFFF, 1'b0);
    run_op("REM 5/0",        3'b110, 32'd5,         32'd0,         5'd16, 32'd5,         1'b0);
    run_op("REM -7/0",       3'b110, 32'hFFFF_FFF9, 32'd0,         5'd18, 32'hFFFF_FFF9, 1'b0);
    run_op("DIV ovf",        3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'h8000_0000, 1'b0);
    run_op("REM ovf",        3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 32'd0,         1'b0);
    run_op("MUL busy-start", 3'b000, 32'd100,       32'd200,       5'd21, 32'd20000,     1'b1);
    // Nothing may follow from the ignored second request.
    we_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (wb_we === 1'b1) we_seen++;
    end
    check("ignored start no wb", 32'(we_seen), 32'd0);
    run_op("MUL rd=0",       3'b000, 32'd4,         32'd5,         5'd0,  32'd20,        1'b0);

    // Reset mid-operation: discard the operation and never write back.
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; op_a = 32'd1234; op_b = 32'd5678; rd = 5'd22;
    @(posedge clk);             // E0
    #1;
    start = 1'b0;
    repeat (14) @(posedge clk); // E14
    #1;
    rst_n = 1'b0;
    #1;
    check("async reset busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    we_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (wb_we === 1'b1) we_seen++;
    end
    check("reset no wb_we", 32'(we_seen), 32'd0);
    check("reset busy idle", 32'(busy), 32'd0);
    run_op("MUL 3x3 post-reset", 3'b000, 32'd3, 32'd3, 5'd23, 32'd9, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

endmodule
